// File: rtl/vga_pkg.sv
// Shared constants and payload types for the VGA frame-synchronous state scheduler.
package vga_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned STAT_W  = 3;

    localparam int unsigned X_MAX_DEF = 624;
    localparam int unsigned Y_MAX_DEF = 464;

    // Scheduler states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_X    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_Y    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 2'd2;

    // {not_started, won, dead}: a fresh game has not started yet
    localparam logic [STAT_W-1:0] STAT_RESET = 3'b100;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } shadow_t;

endpackage

// File: rtl/vga_state_scheduler_if.sv
// CPU write port, frame sync and display-word bus of the state scheduler.
interface vga_state_scheduler_if;
    import vga_pkg::*;

    logic              frame_start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit;
    logic [DATA_W-1:0] disp1;
    logic [DATA_W-1:0] disp2;
    logic              busy;
    logic              commit_drop;
    logic              frame_done;
    logic [DATA_W-1:0] frame_cnt;

    modport master (
        output frame_start, wr_en, wr_addr, wr_data, commit,
        input  disp1, disp2, busy, commit_drop, frame_done, frame_cnt
    );

    modport slave (
        input  frame_start, wr_en, wr_addr, wr_data, commit,
        output disp1, disp2, busy, commit_drop, frame_done, frame_cnt
    );

endinterface

// File: rtl/vga_coord_clamp.sv
// Combinational unsigned clamp of a screen coordinate to its sprite-safe limit.
module vga_coord_clamp
    import vga_pkg::*;
(
    input  logic [COORD_W-1:0] value,
    input  logic [COORD_W-1:0] limit,
    output logic [COORD_W-1:0] clamped_c
);

    assign clamped_c = (value > limit) ? limit : value;

endmodule

// File: rtl/vga_state_scheduler.sv
// Holds CPU game-state commits until the next frame boundary, then swaps the
// clamped shadow registers into the renderer's display words in a single edge.
module vga_state_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned X_MAX = X_MAX_DEF,
    parameter int unsigned Y_MAX = Y_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_state_scheduler_if.slave   bus
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

    logic [1:0]         state;
    logic [1:0]         next_state;
    shadow_t            shadow;
    logic               wr_ok_c;
    logic               drop_c;
    logic               swap_c;
    logic [COORD_W-1:0] x_clamp_c;
    logic [COORD_W-1:0] y_clamp_c;
    logic               unused_wr_bits_c;

    assign unused_wr_bits_c = ^bus.wr_data[DATA_W-1:COORD_W];

    // Next state and pulse decode; a frame_start arriving with the commit is not consumed
    always_comb begin
        next_state = state;
        drop_c     = 1'b0;
        swap_c     = 1'b0;
        wr_ok_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                wr_ok_c = bus.wr_en;
                if (bus.commit) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                drop_c = bus.commit;
                if (bus.frame_start) next_state = ST_SWAP;
            end
            ST_SWAP: begin
                drop_c     = bus.commit;
                swap_c     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Shadow registers only accept writes while no commit is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow.x    <= '0;
            shadow.y    <= '0;
            shadow.stat <= STAT_RESET;
        end else if (wr_ok_c) begin
            case (bus.wr_addr)
                ADDR_X:    shadow.x    <= bus.wr_data[COORD_W-1:0];
                ADDR_Y:    shadow.y    <= bus.wr_data[COORD_W-1:0];
                ADDR_STAT: shadow.stat <= bus.wr_data[STAT_W-1:0];
                default:   ;
            endcase
        end
    end

    vga_coord_clamp u_clamp_x (
        .value     (shadow.x),
        .limit     (X_LIM),
        .clamped_c (x_clamp_c)
    );

    vga_coord_clamp u_clamp_y (
        .value     (shadow.y),
        .limit     (Y_LIM),
        .clamped_c (y_clamp_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.disp1       <= 16'h0000;
            bus.disp2       <= {3'b000, STAT_RESET, COORD_W'(0)};
            bus.busy        <= 1'b0;
            bus.commit_drop <= 1'b0;
            bus.frame_done  <= 1'b0;
        end else begin
            if (swap_c) begin
                bus.disp1 <= {6'b000000, x_clamp_c};
                bus.disp2 <= {3'b000, shadow.stat, y_clamp_c};
            end
            bus.busy        <= (next_state != ST_IDLE);
            bus.commit_drop <= drop_c;
            bus.frame_done  <= swap_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bus.frame_cnt <= '0;
        else if (bus.frame_start) bus.frame_cnt <= bus.frame_cnt + 16'd1;
    end

endmodule

// File: doc/vga_state_scheduler.md
# vga_state_scheduler

Schedules CPU-side game-state updates into the VGA renderer so that every displayed frame shows one coherent ship position and status. The CPU writes X, Y and status into shadow registers, then issues a commit. The block holds the commit until the next frame boundary, clamps the coordinates, and swaps the shadow into the display words. The display words feed the renderer's `in1`/`in2` inputs directly.

## Interface
- `X_MAX`, default 624: largest legal ship X; 640 − 16 sprite width.
- `Y_MAX`, default 464: largest legal ship Y; 480 − 16 sprite height.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse per frame, synchronous to `clk`; the synchronizer is upstream.
- `wr_en`  in  1  shadow register write strobe.
- `wr_addr`  in  2  write address: 0 = X, 1 = Y, 2 = status, 3 = reserved (ignored).
- `wr_data`  in  16  write data. X and Y use bits [9:0]. Status uses [2:0] = {not_started, won, dead}.
- `commit`  in  1  one-cycle request to publish the shadow at the next frame.
- `disp1`  out  16  {6'b0, x[9:0]}; drives renderer `in1`.
- `disp2`  out  16  {3'b0, not_started, won, dead, y[9:0]}; drives renderer `in2`.
- `busy`  out  1  a commit is outstanding.
- `commit_drop`  out  1  one-cycle pulse: a commit was rejected.
- `frame_done`  out  1  one-cycle pulse: the swap completed.
- `frame_cnt`  out  16  count of `frame_start` pulses.

## Operation
- The FSM has three states: IDLE, ARMED, SWAP.
- **IDLE**
  - `commit` moves the FSM to ARMED.
  - `frame_start` does not change state.
- **ARMED**
  - `frame_start` moves the FSM to SWAP.
  - `commit` is rejected and pulses `commit_drop`.
- **SWAP** (one cycle)
  - Loads `disp1`/`disp2` from the clamped shadow.
  - Pulses `frame_done`.
  - Returns to IDLE.
  - `commit` is rejected and pulses `commit_drop`.
- `busy` is 1 in ARMED and SWAP, 0 in IDLE. It is a registered state decode.
- **Shadow writes**
  - Accepted only in IDLE. They land at the clock edge.
  - Writes in ARMED or SWAP are discarded silently; the CPU must poll `busy`.
  - A write and a commit in the same IDLE cycle: the write lands and is included in that commit.
- **Clamp**
  - x_out = min(x, X_MAX) and y_out = min(y, Y_MAX), as unsigned 10-bit compares.
  - Shadow bits [15:10] of X and Y are ignored.
- Status bits pass through unmodified.
- Commit and `frame_start` in the same IDLE cycle: the FSM goes to ARMED, and that `frame_start` is not consumed. The swap waits for the next frame.
- `frame_cnt` increments on every `frame_start` in every state and wraps from 0xFFFF to 0x0000.
- Reset values:
  - State = IDLE.
  - Shadow X = 0, Y = 0, status = 3'b100.
  - `disp1` = 16'h0000, `disp2` = 16'h1000.
  - `busy` = 0, `commit_drop` = 0, `frame_done` = 0, `frame_cnt` = 0.
- Reset mid-operation returns everything to the reset values on the asserting edge. Any pending commit is lost.

## Timing
- Commit sampled at edge t (FSM in IDLE): state = ARMED and `busy` = 1 after t.
- `frame_start` sampled at edge f in ARMED: state = SWAP after f.
- At edge f+1:
  - `disp1`/`disp2` take the new values.
  - `frame_done` = 1 for the cycle after f+1.
  - State = IDLE and `busy` = 0.
- Latency from `frame_start` to new display words: 2 edges.
- Display words change only at that single edge. They are stable for the rest of the frame, so the renderer's own vblank latch always sees a coherent pair.
- `commit_drop` and `frame_done` are registered single-cycle pulses.
- Minimum commit-to-commit interval: commit, then ≥1 `frame_start`, then ≥2 cycles.
- `frame_cnt` updates at the same edge that samples `frame_start`.

## Structure
- Package `vga_pkg` holds:
  - the state enum (IDLE, ARMED, SWAP);
  - the address constants ADDR_X, ADDR_Y, ADDR_STAT;
  - the reset status 3'b100;
  - the `X_MAX`/`Y_MAX` defaults.
- Sub-module `vga_coord_clamp` is combinational: a 10-bit value and a 10-bit limit in, the clamped value out. It is instantiated twice, for X and Y.
- The FSM, shadow registers, output registers and frame counter all live in the top module.

## Test plan
- **Reset:** assert `rst` mid-cycle → `disp2` = 0x1000 and `busy` = 0 immediately, `frame_cnt` = 0.
- **Basic swap:** write X = 100, Y = 200, status = 3'b000, then commit; wait; pulse `frame_start` → `disp1` = 0x0064 and `disp2` = 0x00C8 two edges after `frame_start`; `frame_done` pulses once; `busy` then drops.
- **Clamp:** write X = 0x3FF, Y = 500, commit, frame → `disp1` = 0x0270 (624), `disp2` low bits = 464.
- **Rejection:** commit, then write X = 5 and a second commit while ARMED → the write is ignored, `commit_drop` pulses once, and the swap shows the first value.
- **Simultaneous events:** commit and `frame_start` in the same IDLE cycle → no swap on that frame; the swap happens on the next `frame_start`; `frame_cnt` increments on both.
- **Wrap:** preload `frame_cnt` to 0xFFFF via 65535 `frame_start` pulses (or a force), pulse `frame_start` once more → `frame_cnt` = 0x0000.
